spi_slave: RTL and testbench

//  Bit-bang SPI slave (mode 0: CPOL=0, CPHA=0, MSB first), the device-side peer of spi_master.

---
 rtl/spi_slave.sv | 168 ++++++++++++++++
 tb/tb_spi_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 slave (CPOL=0, CPHA=0, MSB first), oversampled in
//                the system clock domain. Received words go to a put-strobe
//                sink; transmit words come from an empty/get source.
//                Optional macro SPI_SLAVE_TRISTATE_EN: MISO floats (z) while
//                idle or in reset, for use on a shared MISO bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int           W    = 8,
    parameter logic [W-1:0] FILL = {W{1'b1}}
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso
);

    localparam int           CW     = $clog2(W + 1);
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_cs_s1, r_cs_s2, r_cs_s3;
    logic           r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic           r_mosi_s1, r_mosi_s2;
    logic [1:0]     r_sync_fill;
    logic           r_armed;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_rx;
    logic [W-1:0]   r_tx;
    logic [W-1:0]   r_out;
    logic           r_get, r_put;

    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic w_start, w_stop, w_rx_shift, w_word_done, w_tx_shift, w_load;

    // Two-flop synchronisers plus a third flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cs_s1     <= 1'b1;
            r_cs_s2     <= 1'b1;
            r_cs_s3     <= 1'b1;
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_s3   <= 1'b0;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_sync_fill <= 2'b00;
        end else begin
            r_cs_s1     <= spi_cs_n;
            r_cs_s2     <= r_cs_s1;
            r_cs_s3     <= r_cs_s2;
            r_sclk_s1   <= spi_clock;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_s3   <= r_sclk_s2;
            r_mosi_s1   <= spi_mosi;
            r_mosi_s2   <= r_mosi_s1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
        end
    end

    assign w_cs_fall   =  r_cs_s3   & ~r_cs_s2;
    assign w_cs_rise   = ~r_cs_s3   &  r_cs_s2;
    assign w_sclk_rise = ~r_sclk_s3 &  r_sclk_s2;
    assign w_sclk_fall =  r_sclk_s3 & ~r_sclk_s2;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle datapath controls; cs_n rising beats sclk edges
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_rx_shift  = 1'b0;
        w_word_done = 1'b0;
        w_tx_shift  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_stop      = 1'b1;
                end else if (w_sclk_rise) begin
                    w_rx_shift  = 1'b1;
                    w_word_done = (r_count == c_LAST);
                end else if (w_sclk_fall && (r_count != '0)) begin
                    w_tx_shift  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load = w_start | w_word_done;

    // Shift registers, bit count, output word and strobes. A falling edge is
    // only accepted after cs_n has genuinely been seen high since reset, so a
    // reset during a held-low frame cannot restart it spuriously.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_count <= '0;
            r_rx    <= '0;
            r_tx    <= '0;
            r_out   <= '0;
            r_get   <= 1'b0;
            r_put   <= 1'b0;
        end else begin
            r_get <= w_load & ~empty;
            r_put <= w_word_done;
            if (w_start)
                r_armed <= 1'b0;
            else if ((r_state == S_IDLE) && r_cs_s2 && r_sync_fill[1])
                r_armed <= 1'b1;
            if (w_start) begin
                r_count <= '0;
                r_rx    <= '0;
            end
            if (w_stop)
                r_count <= '0;
            if (w_rx_shift) begin
                r_rx    <= {r_rx[W-2:0], r_mosi_s2};
                r_count <= w_word_done ? '0 : r_count + 1'b1;
            end
            if (w_word_done)
                r_out <= {r_rx[W-2:0], r_mosi_s2};
            if (w_load)
                r_tx <= empty ? FILL : in;
            else if (w_tx_shift)
                r_tx <= {r_tx[W-2:0], 1'b0};
        end
    end

    assign get = r_get;
    assign put = r_put;
    assign out = r_out;

`ifdef SPI_SLAVE_TRISTATE_EN
    assign spi_miso = ((r_state == S_ACTIVE) && !reset) ? r_tx[W-1] : 1'bz;
`else
    assign spi_miso = ((r_state == S_ACTIVE) && !reset) ? r_tx[W-1] : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Directed self-checking bench; acts as mode-0 SPI master with
//                a half-period of 10 system clocks and models the word source.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic [7:0] w_in;
    logic       w_get;
    logic       w_empty;
    logic [7:0] w_out;
    logic       w_put;
    logic       r_cs_n;
    logic       r_sclk;
    logic       r_mosi_drv;
    logic       r_loop;
    logic       w_mosi;
    logic       w_miso;

    int         n_checks = 0;
    int         n_fail   = 0;

    // Word source: written by the stimulus, popped on get
    logic [7:0] src_mem [0:63];
    int         src_wr = 0;
    int         src_rd = 0;

    // Strobe monitor
    int         get_cnt = 0;
    int         put_cnt = 0;
    logic [7:0] put_vals [0:63];

    spi_slave #(.W(8), .FILL(8'hFF)) u_dut (
        .clock     (clk),
        .reset     (rst),
        .in        (w_in),
        .get       (w_get),
        .empty     (w_empty),
        .out       (w_out),
        .put       (w_put),
        .spi_cs_n  (r_cs_n),
        .spi_clock (r_sclk),
        .spi_mosi  (w_mosi),
        .spi_miso  (w_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_mosi  = r_loop ? w_miso : r_mosi_drv;
    assign w_empty = (src_rd == src_wr);
    assign w_in    = src_mem[src_rd[5:0]];

    always @(posedge clk) begin
        if (w_get && !w_empty) src_rd <= src_rd + 1;
    end

    always @(negedge clk) begin
        if (w_get) get_cnt <= get_cnt + 1;
        if (w_put) begin
            put_vals[put_cnt[5:0]] <= w_out;
            put_cnt <= put_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        src_mem[src_wr[5:0]] = v;
        src_wr = src_wr + 1;
    endtask

    task automatic half_period();
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Drop cs_n and report how many clocks until get is first seen (0 = never)
    task automatic cs_low(output int lat);
        lat = 0;
        r_cs_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (w_get && lat == 0) lat = i;
        end
    endtask

    task automatic cs_high();
        half_period();
        r_cs_n = 1'b1;
        half_period();
    endtask

    // Shift nbits of tx out MSB first; capture MISO on each rising sclk
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            r_mosi_drv = tx[7-b];
            half_period();
            r_sclk = 1'b1;
            rx = {rx[6:0], w_miso};
            half_period();
            r_sclk = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         g0, p0;
        logic [7:0] rx0, rx1;

        rst        = 1'b1;
        r_cs_n     = 1'b1;
        r_sclk     = 1'b0;
        r_mosi_drv = 1'b0;
        r_loop     = 1'b0;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_put",  {31'b0, w_put},  32'd0);
        check_val("rst_get",  {31'b0, w_get},  32'd0);
        check_val("rst_out",  {24'b0, w_out},  32'h00);
        check_val("rst_miso", {31'b0, w_miso}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 2. single word A5 out, 3C in
        push_word(8'hA5);
        g0 = get_cnt; p0 = put_cnt;
        cs_low(lat);
        check_val("t2_get_lat", lat, 32'd3);
        xfer(8'h3C, 8, rx0);
        cs_high();
        check_val("t2_miso",   {24'b0, rx0},            32'hA5);
        check_val("t2_gets",   get_cnt - g0,            32'd1);
        check_val("t2_puts",   put_cnt - p0,            32'd1);
        check_val("t2_putval", {24'b0, put_vals[p0[5:0]]}, 32'h3C);
        check_val("t2_out",    {24'b0, w_out},          32'h3C);

        // 3. empty source -> FILL
        g0 = get_cnt; p0 = put_cnt;
        cs_low(lat);
        xfer(8'h00, 8, rx0);
        cs_high();
        check_val("t3_miso", {24'b0, rx0},   32'hFF);
        check_val("t3_gets", get_cnt - g0,   32'd0);
        check_val("t3_puts", put_cnt - p0,   32'd1);
        check_val("t3_out",  {24'b0, w_out}, 32'h00);

        // 4. two words in one frame, source "Hi"
        push_word(8'h48);
        push_word(8'h69);
        g0 = get_cnt; p0 = put_cnt;
        cs_low(lat);
        xfer(8'h11, 8, rx0);
        xfer(8'h22, 8, rx1);
        cs_high();
        check_val("t4_miso0", {24'b0, rx0},                    32'h48);
        check_val("t4_miso1", {24'b0, rx1},                    32'h69);
        check_val("t4_gets",  get_cnt - g0,                    32'd2);
        check_val("t4_puts",  put_cnt - p0,                    32'd2);
        check_val("t4_put0",  {24'b0, put_vals[p0[5:0]]},      32'h11);
        check_val("t4_put1",  {24'b0, put_vals[(p0 + 1) & 63]}, 32'h22);

        // 5. aborted frame after 5 edges, then a full frame
        push_word(8'h77);
        g0 = get_cnt; p0 = put_cnt;
        cs_low(lat);
        xfer(8'hF0, 5, rx0);
        cs_high();
        check_val("t5_abort_puts", put_cnt - p0,   32'd0);
        check_val("t5_abort_out",  {24'b0, w_out}, 32'h22);
        check_val("t5_abort_gets", get_cnt - g0,   32'd1);
        push_word(8'h96);
        g0 = get_cnt; p0 = put_cnt;
        cs_low(lat);
        check_val("t5_get_lat", lat, 32'd3);
        xfer(8'h5A, 8, rx0);
        cs_high();
        check_val("t5_miso", {24'b0, rx0},   32'h96);
        check_val("t5_gets", get_cnt - g0,   32'd1);
        check_val("t5_puts", put_cnt - p0,   32'd1);
        check_val("t5_out",  {24'b0, w_out}, 32'h5A);

        // 6. loopback
        r_loop = 1'b1;
        push_word(8'hC3);
        p0 = put_cnt;
        cs_low(lat);
        xfer(8'h00, 8, rx0);
        cs_high();
        check_val("t6_loop_miso", {24'b0, rx0},   32'hC3);
        check_val("t6_loop_puts", put_cnt - p0,   32'd1);
        check_val("t6_loop_out",  {24'b0, w_out}, 32'hC3);

        // 6b. loopback with reset mid-frame
        push_word(8'h0F);
        cs_low(lat);
        xfer(8'h00, 4, rx0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("t6_rst_put",  {31'b0, w_put},  32'd0);
        check_val("t6_rst_get",  {31'b0, w_get},  32'd0);
        check_val("t6_rst_out",  {24'b0, w_out},  32'h00);
        check_val("t6_rst_miso", {31'b0, w_miso}, 32'd0);
        g0 = get_cnt; p0 = put_cnt;
        xfer(8'h00, 4, rx0);
        cs_high();
        check_val("t6_rst_puts_after", put_cnt - p0,   32'd0);
        check_val("t6_rst_gets_after", get_cnt - g0,   32'd0);
        check_val("t6_rst_out_after",  {24'b0, w_out}, 32'h00);
        r_loop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
